// File: rtl/bitstream_frame_loader_pkg.sv
// Shared types and constants for the bitstream frame loader.
package bitstream_frame_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Drop byte b into lane idx (0 = [31:24]); lanes below idx come out zero.
  function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] b,
                                            input logic [1:0] idx);
    logic [31:0] r;
    case (idx)
      2'd0:    r = {b, 24'h0};
      2'd1:    r = {word[31:24], b, 16'h0};
      2'd2:    r = {word[31:16], b, 8'h0};
      default: r = {word[31:8], b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitstream_frame_loader_if.sv
// Byte input stream plus config-memory write port and frame status.
interface bitstream_frame_loader_if #(parameter int ADDR_WIDTH = 12);
  logic [7:0]            data_in;
  logic                  valid_in;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [1:0]            err_code;
  logic [15:0]           byte_count;

  modport master (output data_in, valid_in,
                  input wr_en, wr_addr, wr_data, busy, done, error, err_code, byte_count);
  modport slave  (input data_in, valid_in,
                  output wr_en, wr_addr, wr_data, busy, done, error, err_code, byte_count);
endinterface

// File: rtl/bitstream_frame_loader_timer.sv
// Inter-byte watchdog: cleared while disabled or on reload, expires TIMEOUT_CYCLES after the last reload.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_reload,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !i_en || i_reload) r_cnt <= '0;
    else if (!o_expire)           r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/bitstream_frame_loader.sv
// Frame parser: SYNC, 16-bit length, payload packed into 32-bit words, mod-256 checksum.
module bitstream_frame_loader
  import bitstream_frame_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input logic                      clk,
  input logic                      rst,
  bitstream_frame_loader_if.slave  bus
);
  localparam logic [16:0] MAX_BYTES = 17'(4 << ADDR_WIDTH);

  state_e                r_state;
  logic                  r_wr_en, r_busy, r_done, r_error;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data, r_word;
  logic [1:0]            r_err_code;
  logic [15:0]           r_byte_count, r_len;
  logic [7:0]            r_sum;

  logic        w_expire, w_last;
  logic [15:0] w_len, w_cnt_nxt;
  logic [31:0] w_word_nxt;

  assign w_len      = {r_len[15:8], bus.data_in};
  assign w_cnt_nxt  = r_byte_count + 16'd1;
  assign w_last     = (w_cnt_nxt == r_len);
  assign w_word_nxt = pack_byte(r_word, bus.data_in, r_byte_count[1:0]);

  frame_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_busy),
    .i_reload (bus.valid_in),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_byte_count <= '0;
      r_len        <= '0;
      r_sum        <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en) r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);

      // A byte landing on the expiry cycle wins over the timeout.
      if (w_expire && !bus.valid_in) begin
        r_state    <= S_ERROR;
        r_busy     <= 1'b0;
        r_error    <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
      end else if (bus.valid_in) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: if (bus.data_in == SYNC_BYTE) begin
            r_state      <= S_LEN_HI;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_byte_count <= '0;
            r_sum        <= '0;
            r_wr_addr    <= '0;
          end
          S_LEN_HI: begin
            r_len[15:8] <= bus.data_in;
            r_state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len[7:0] <= bus.data_in;
            if (w_len == 16'd0 || {1'b0, w_len} > MAX_BYTES) begin
              r_state    <= S_ERROR;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
              r_err_code <= ERR_LEN;
            end else begin
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_word       <= w_word_nxt;
            r_sum        <= r_sum + bus.data_in;
            r_byte_count <= w_cnt_nxt;
            if (r_byte_count[1:0] == 2'd3 || w_last) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_word_nxt;
            end
            if (w_last) r_state <= S_CHECK;
          end
          S_CHECK: begin
            r_busy <= 1'b0;
            if (bus.data_in == r_sum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ERROR;
              r_error    <= 1'b1;
              r_err_code <= ERR_CHK;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.err_code   = r_err_code;
  assign bus.byte_count = r_byte_count;
endmodule

// File: tb/tb_bitstream_frame_loader.sv
// Directed frames; expected writes and end-of-frame status are queued and checked by a monitor.
module tb_bitstream_frame_loader;
  import bitstream_frame_loader_pkg::*;

  localparam int AW = 4;
  localparam int TO = 50;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct packed {
    logic        done;
    logic        error;
    logic [1:0]  code;
    logic [15:0] cnt;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  wr_t  wq[$];
  st_t  sq[$];
  logic prev_flag = 1'b0;

  always #5 clk = ~clk;

  bitstream_frame_loader_if #(.ADDR_WIDTH(AW)) bus();

  bitstream_frame_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
  endtask

  task automatic check_reset_state();
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done_error", 64'({bus.done, bus.error}), 64'd0);
    chk("rst_err_code", 64'(bus.err_code), 64'd0);
    chk("rst_byte_count", 64'(bus.byte_count), 64'd0);
  endtask

  // Monitor: every write and every rising done/error is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        n_chk++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %08h with nothing expected", bus.wr_addr, bus.wr_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
            n_fail++;
            $display("FAIL write: got addr %0h data %08h expected addr %0h data %08h",
                     bus.wr_addr, bus.wr_data, e.addr, e.data);
          end
        end
      end
      if ((bus.done || bus.error) && !prev_flag) begin
        n_chk++;
        if (sq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_status: done %0b error %0b code %0d", bus.done, bus.error, bus.err_code);
        end else begin
          st_t e;
          e = sq.pop_front();
          if ({bus.done, bus.error, bus.err_code, bus.byte_count} !== e) begin
            n_fail++;
            $display("FAIL status: got done %0b error %0b code %0d count %0d expected done %0b error %0b code %0d count %0d",
                     bus.done, bus.error, bus.err_code, bus.byte_count, e.done, e.error, e.code, e.cnt);
          end
        end
      end
      if (bus.done && bus.error) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_error_exclusive: both high");
      end
    end
    prev_flag = !rst && (bus.done || bus.error);
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    idle(2);
    check_reset_state();
    rst = 1'b0;
    idle(2);

    // 5-byte frame: one full word and one partial word.
    wq.push_back('{4'd0, 32'h11223344});
    wq.push_back('{4'd1, 32'h55000000});
    sq.push_back('{1'b1, 1'b0, ERR_NONE, 16'd5});
    send(8'hA5); send(8'h00); send(8'h05);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    send(8'hFF);
    idle(3);

    // Checksum mismatch after one full word.
    wq.push_back('{4'd0, 32'h01020304});
    sq.push_back('{1'b0, 1'b1, ERR_CHK, 16'd4});
    send(8'hA5); send(8'h00); send(8'h04);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h00);
    idle(3);

    // Zero length, then one byte above the 64-byte maximum.
    sq.push_back('{1'b0, 1'b1, ERR_LEN, 16'd0});
    send(8'hA5); send(8'h00); send(8'h00);
    idle(3);
    sq.push_back('{1'b0, 1'b1, ERR_LEN, 16'd0});
    send(8'hA5); send(8'h00); send(8'h41);
    idle(3);

    // Exactly the maximum length is accepted; reset after two payload bytes.
    send(8'hA5); send(8'h00); send(8'h40);
    chk("max_len_busy", 64'(bus.busy), 64'd1);
    chk("max_len_no_error", 64'(bus.error), 64'd0);
    send(8'hAA); send(8'hBB);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_state();
    idle(2);
    wq.push_back('{4'd0, 32'h7E000000});
    sq.push_back('{1'b1, 1'b0, ERR_NONE, 16'd1});
    send(8'hA5); send(8'h00); send(8'h01); send(8'h7E); send(8'h7E);
    idle(3);

    // SYNC value inside a frame is plain payload.
    wq.push_back('{4'd0, 32'hA5A50000});
    sq.push_back('{1'b1, 1'b0, ERR_NONE, 16'd2});
    send(8'hA5); send(8'h00); send(8'h02); send(8'hA5); send(8'hA5); send(8'h4A);
    idle(3);

    // Timeout after three payload bytes fires exactly TO cycles after the last byte.
    sq.push_back('{1'b0, 1'b1, ERR_TIMEOUT, 16'd3});
    send(8'hA5); send(8'h00); send(8'h08); send(8'h01); send(8'h02); send(8'h03);
    idle(TO - 1);
    chk("timeout_not_early", 64'(bus.error), 64'd0);
    idle(1);
    chk("timeout_fired", 64'({bus.error, bus.err_code}), 64'({1'b1, ERR_TIMEOUT}));
    idle(5);

    // Bytes landing on the expiry cycle are accepted.
    wq.push_back('{4'd0, 32'h11220000});
    sq.push_back('{1'b1, 1'b0, ERR_NONE, 16'd2});
    send(8'hA5); send(8'h00); send(8'h02); send(8'h11);
    idle(TO - 1);
    send(8'h22);
    idle(TO - 1);
    send(8'h33);
    idle(5);

    chk("writes_outstanding", 64'(wq.size()), 64'd0);
    chk("status_outstanding", 64'(sq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
